// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the BCD seven-segment
//                counter: BCD nibble type, the largest legal BCD digit and
//                the active-high {g,f,e,d,c,b,a} pattern for each glyph.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal nibbles are treated as zero wherever a BCD value enters.
    function automatic bcd_t bcd_sanitize(input bcd_t d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_decode
//  Description : Combinational BCD to seven-segment decoder for one digit.
//  Ports       : nibble     - BCD digit to show
//                blank      - 1 forces all segments off
//                active_low - 1 inverts the output (segment on when 0)
//                pattern    - {g,f,e,d,c,b,a}
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seg_decode
    import seg_pkg::*;
(
    input  bcd_t       nibble,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] pattern
);

    logic [6:0] w_glyph;

    always_comb begin
        w_glyph = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    w_glyph = SEG_0;
                4'd1:    w_glyph = SEG_1;
                4'd2:    w_glyph = SEG_2;
                4'd3:    w_glyph = SEG_3;
                4'd4:    w_glyph = SEG_4;
                4'd5:    w_glyph = SEG_5;
                4'd6:    w_glyph = SEG_6;
                4'd7:    w_glyph = SEG_7;
                4'd8:    w_glyph = SEG_8;
                4'd9:    w_glyph = SEG_9;
                default: w_glyph = SEG_BLANK;
            endcase
        end
    end

    assign pattern = active_low ? ~w_glyph : w_glyph;

endmodule : bcd_seg_decode
`default_nettype wire

// File: rtl/bcd_seg_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_counter
//  Description : Multi-digit BCD up/down counter with prescaler, clear,
//                parallel load, wrap flag and per-digit seven-segment decode
//                with optional leading-zero blanking.
//  Ports       : clk, rst_n (async, active low)
//                en        - count enable, gates the prescaler
//                up_dn     - 1 up, 0 down (sampled on the step cycle)
//                clr       - synchronous clear (highest priority)
//                load      - synchronous parallel load of load_val
//                load_val  - BCD value, digit 0 in [3:0]
//                count_bcd - registered BCD count
//                seg       - 7 bits per digit, digit 0 in [6:0]
//                tick      - one-cycle pulse with each count step
//                wrap      - one-cycle pulse when the count wraps
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seg_counter
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    tick,
    output logic                    wrap
);

    localparam int              c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

    logic [c_PS_W-1:0]       r_pre;
    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_tick;
    logic                    r_wrap;

    logic                    w_step;
    logic [4*NUM_DIGITS-1:0] w_step_next;
    logic                    w_step_wrap;
    logic [4*NUM_DIGITS-1:0] w_load_clean;
    logic [NUM_DIGITS-1:0]   w_blank;

    assign w_step = en && (r_pre == c_PS_LAST);

    // Ripple carry (up) or borrow (down) from digit 0 upward. A carry/borrow
    // that survives past the top digit means the whole count wrapped.
    always_comb begin
        logic cy;
        bcd_t d;
        cy          = 1'b1;
        w_step_next = r_count;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = r_count[4*k +: 4];
            if (cy) begin
                if (up_dn) begin
                    if (d >= BCD_MAX) begin
                        d = 4'd0;
                    end else begin
                        d  = d + 4'd1;
                        cy = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = BCD_MAX;
                    end else begin
                        d  = d - 4'd1;
                        cy = 1'b0;
                    end
                end
            end
            w_step_next[4*k +: 4] = d;
        end
        w_step_wrap = cy;
    end

    always_comb begin
        w_load_clean = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_load_clean[4*k +: 4] = bcd_sanitize(load_val[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (clr) begin
                r_pre   <= '0;
                r_count <= '0;
            end else if (load) begin
                r_pre   <= '0;
                r_count <= w_load_clean;
            end else if (w_step) begin
                r_pre   <= '0;
                r_count <= w_step_next;
                r_tick  <= 1'b1;
                r_wrap  <= w_step_wrap;
            end else if (en) begin
                r_pre   <= r_pre + 1'b1;
            end
        end
    end

    assign count_bcd = r_count;
    assign tick      = r_tick;
    assign wrap      = r_wrap;

    // Scan from the top digit down: a digit is blank while every digit at
    // or above it is zero. Digit 0 always shows.
    always_comb begin
        logic nz;
        nz      = 1'b0;
        w_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            nz         = nz | (r_count[4*k +: 4] != 4'd0);
            w_blank[k] = (BLANK_LEADING != 0) && !nz;
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_seg_decode u_dec (
                .nibble     (r_count[4*g +: 4]),
                .blank      (w_blank[g]),
                .active_low (SEG_ACTIVE_LOW != 0),
                .pattern    (seg[7*g +: 7])
            );
        end
    endgenerate

endmodule : bcd_seg_counter
`default_nettype wire

// File: tb/tb_bcd_seg_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seg_counter
//  Description : Directed self-checking bench for bcd_seg_counter with
//                NUM_DIGITS=2, PRESCALE=4, active-low segments, blanking on.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_seg_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  count_bcd;
    logic [13:0] seg;
    logic        tick;
    logic        wrap;

    int checks   = 0;
    int failures = 0;
    int n;

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] L0 = 7'b1000000;
    localparam logic [6:0] L1 = 7'b1111001;
    localparam logic [6:0] L9 = 7'b0010000;
    localparam logic [6:0] LB = 7'b1111111;

    bcd_seg_counter #(
        .NUM_DIGITS(2), .PRESCALE(4), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .count_bcd(count_bcd),
        .seg(seg), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until tick is seen (bounded); returns edges taken.
    task automatic run_to_tick(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!tick && cnt < 20);
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cyc();
        load     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
        cyc(); cyc();
        check("rst_count", {24'd0, count_bcd}, 32'h00);
        check("rst_seg",   {18'd0, seg}, {18'd0, LB, L0});
        check("rst_tick",  {31'd0, tick}, 32'd0);
        check("rst_wrap",  {31'd0, wrap}, 32'd0);

        rst_n = 1'b1; en = 1'b1;
        cyc(); check("pre1_tick", {31'd0, tick}, 32'd0);
        cyc(); check("pre2_tick", {31'd0, tick}, 32'd0);
        cyc(); check("pre3_tick", {31'd0, tick}, 32'd0);
        cyc();
        check("first_tick",  {31'd0, tick}, 32'd1);
        check("first_count", {24'd0, count_bcd}, 32'h01);
        check("seg_01",      {18'd0, seg}, {18'd0, LB, L1});
        cyc(); check("tick_pulse", {31'd0, tick}, 32'd0);

        // Up wrap 98 -> 99 -> 00
        do_load(8'h98);
        check("load98", {24'd0, count_bcd}, 32'h98);
        check("load98_tick", {31'd0, tick}, 32'd0);
        run_to_tick(n);
        check("up_lat", n, 32'd4);
        check("up_99", {24'd0, count_bcd}, 32'h99);
        check("up_99_wrap", {31'd0, wrap}, 32'd0);
        run_to_tick(n);
        check("up_00", {24'd0, count_bcd}, 32'h00);
        check("up_wrap", {31'd0, wrap}, 32'd1);
        check("seg_00", {18'd0, seg}, {18'd0, LB, L0});
        cyc(); check("wrap_pulse", {31'd0, wrap}, 32'd0);

        // Down wrap 00 -> 99
        do_load(8'h00);
        up_dn = 1'b0;
        run_to_tick(n);
        check("dn_lat", n, 32'd4);
        check("dn_99", {24'd0, count_bcd}, 32'h99);
        check("dn_wrap", {31'd0, wrap}, 32'd1);
        check("seg_99", {18'd0, seg}, {18'd0, L9, L9});

        // Borrow 10 -> 09
        do_load(8'h10);
        run_to_tick(n);
        check("dn_borrow", {24'd0, count_bcd}, 32'h09);
        check("dn_borrow_wrap", {31'd0, wrap}, 32'd0);

        // Carry 09 -> 10
        up_dn = 1'b1;
        do_load(8'h09);
        run_to_tick(n);
        check("up_carry", {24'd0, count_bcd}, 32'h10);
        check("seg_10", {18'd0, seg}, {18'd0, L1, L0});

        // Pause mid-prescale
        cyc(); check("ps_a", {31'd0, tick}, 32'd0);
        cyc(); check("ps_b", {31'd0, tick}, 32'd0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("paused_tick", {31'd0, tick}, 32'd0);
        end
        check("paused_count", {24'd0, count_bcd}, 32'h10);
        en = 1'b1;
        cyc(); check("resume_a", {31'd0, tick}, 32'd0);
        cyc();
        check("resume_tick", {31'd0, tick}, 32'd1);
        check("resume_count", {24'd0, count_bcd}, 32'h11);

        // clr beats load
        clr = 1'b1; load = 1'b1; load_val = 8'h55;
        cyc();
        clr = 1'b0; load = 1'b0;
        check("clr_prio", {24'd0, count_bcd}, 32'h00);
        check("clr_tick", {31'd0, tick}, 32'd0);

        do_load(8'hA3);
        check("load_A3", {24'd0, count_bcd}, 32'h03);
        do_load(8'hF9);
        check("load_F9", {24'd0, count_bcd}, 32'h09);

        // Async reset mid-count
        do_load(8'h57);
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", {24'd0, count_bcd}, 32'h00);
        check("arst_seg",   {18'd0, seg}, {18'd0, LB, L0});
        check("arst_tick",  {31'd0, tick}, 32'd0);
        cyc();
        rst_n = 1'b1;
        run_to_tick(n);
        check("post_rst_lat", n, 32'd4);
        check("post_rst_count", {24'd0, count_bcd}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd_seg_counter
`default_nettype wire
